// File: rtl/sysbus_arbiter.sv
// rtl/sysbus_arbiter.sv - round-robin arbiter sharing one Sysbus channel among N_REQ requesters
module sysbus_arbiter #(
  parameter int N_REQ = 3,
  parameter int BEATS = 8,
  parameter int TAG_W = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         rq_cyc,
  input  logic [N_REQ*64-1:0]      rq_addr,
  input  logic [N_REQ*TAG_W-1:0]   rq_tag,
  output logic [N_REQ-1:0]         rq_ack,
  output logic [N_REQ-1:0]         rs_cyc,
  output logic [63:0]              rs_data,
  output logic                     bus_reqcyc,
  output logic [63:0]              bus_req,
  output logic [TAG_W-1:0]         bus_reqtag,
  input  logic                     bus_reqack,
  input  logic                     bus_respcyc,
  input  logic [63:0]              bus_resp,
  output logic                     bus_respack
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST_R = CW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_W = CW'((BEATS > 1) ? BEATS - 2 : 0);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

  state_t           state, state_nxt;
  logic [OW-1:0]    owner, rr_ptr, grant_idx, owner_inc;
  logic             grant_vld;
  logic [CW-1:0]    beat_cnt;
  logic [TAG_W-1:0] tag_q;
  logic             stray_resp;
  logic [63:0]      own_addr;
  logic [TAG_W-1:0] own_tag;
  logic             is_read;

  assign own_addr  = rq_addr[64*owner +: 64];
  assign own_tag   = rq_tag[TAG_W*owner +: TAG_W];
  assign is_read   = tag_q[TAG_W-1];
  assign owner_inc = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rq_cyc[(int'(rr_ptr) + k) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = OW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    rq_ack      = '0;
    rs_cyc      = '0;
    rs_data     = '0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) state_nxt = REQ;
      end
      REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = {own_addr[63:6], 6'b0};
        bus_reqtag = own_tag;
        if (bus_reqack) begin
          rq_ack[owner] = 1'b1;
          if (is_read)        state_nxt = RESP;
          else if (BEATS > 1) state_nxt = WDATA;
          else                state_nxt = IDLE;
        end
      end
      WDATA: begin
        bus_reqcyc = 1'b1;
        bus_req    = own_addr;
        bus_reqtag = tag_q;
        if (bus_reqack) begin
          rq_ack[owner] = 1'b1;
          if (beat_cnt == LAST_W) state_nxt = IDLE;
        end
      end
      RESP: begin
        bus_respack   = bus_respcyc;
        rs_cyc[owner] = bus_respcyc;
        rs_data       = bus_resp;
        if (bus_respcyc && beat_cnt == LAST_R) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      tag_q      <= '0;
      stray_resp <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner <= grant_idx;
            tag_q <= rq_tag[TAG_W*grant_idx +: TAG_W];
          end
        end
        REQ: begin
          if (bus_reqack) begin
            rr_ptr   <= owner_inc;
            beat_cnt <= '0;
          end
        end
        WDATA: if (bus_reqack) beat_cnt <= beat_cnt + 1'b1;
        RESP:  if (bus_respcyc) beat_cnt <= beat_cnt + 1'b1;
        default: ;
      endcase
      // Responses with no read in flight are dropped; remember that it happened.
      if (bus_respcyc && state != RESP) stray_resp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && state == REQ)
      assert (rq_cyc[owner]) else $fatal(1, "rq_cyc withdrawn before bus_reqack");
  end

endmodule
